// File: rtl/axil_mon_pkg.sv
// Shared types and helpers for the AXI-Lite style handshake monitor.
package axil_mon_pkg;

  // Error codes reported on err_code; 0 means "no error", 5..7 unused.
  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_VALID_DROP    = 3'd1,
    ERR_DATA_CHANGE   = 3'd2,
    ERR_STALL_TIMEOUT = 3'd3,
    ERR_PASS_TIMEOUT  = 3'd4
  } err_code_e;

  // Per-channel handshake tracking state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ch_state_e;

  // Number of distinct error codes; bit (code-1) of a channel error vector.
  localparam int ERR_NUM = 4;
  localparam int ERR_BIT_DROP  = 0;
  localparam int ERR_BIT_DATA  = 1;
  localparam int ERR_BIT_STALL = 2;
  localparam int ERR_BIT_PASS  = 3;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Saturation flag for an accumulator of width sum_w compared with a
  // counter of width cnt_w: true when sum exceeds the all-ones counter value.
  function automatic logic sat_hit(input logic [63:0] sum, input int cnt_w);
    logic [63:0] lim;
    lim = (64'd1 << cnt_w) - 64'd1;
    return sum > lim;
  endfunction

endpackage

// File: rtl/axil_mon_channel.sv
// One monitored valid/ready channel: IDLE/WAIT protocol FSM with payload
// capture, a stall timer while waiting, and a pass timer that expects the
// paired downstream valid within PASS_MAX cycles of an upstream handshake.
// Handshake: a transfer happens on a clock edge where valid && ready; once
// valid rises it must stay high with stable data until ready is seen.
module axil_mon_channel
  import axil_mon_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STALL_MAX = 16,
  parameter int PASS_MAX  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               ready,
  input  logic [DATA_W-1:0]  data,
  input  logic               dn_valid,
  output logic [ERR_NUM-1:0] err,
  output ch_state_e          state
);

  localparam int STALL_W = cnt_width(STALL_MAX);
  localparam int PASS_W  = cnt_width(PASS_MAX);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  localparam logic [PASS_W-1:0]  PASS_LIM  = PASS_W'(PASS_MAX);
  localparam logic [PASS_W-1:0]  PASS_ONE  = PASS_W'(1);

  ch_state_e          state_nxt;
  logic [DATA_W-1:0]  cap, cap_nxt;
  logic [STALL_W-1:0] stall_cnt, stall_nxt;
  logic               pass_armed, armed_nxt;
  logic [PASS_W-1:0]  pass_cnt, pass_nxt;
  logic               hs;

  // State, capture and timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cap        <= '0;
      stall_cnt  <= '0;
      pass_armed <= 1'b0;
      pass_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cap        <= cap_nxt;
      stall_cnt  <= stall_nxt;
      pass_armed <= armed_nxt;
      pass_cnt   <= pass_nxt;
    end
  end

  // Next-state logic and combinational error detection for this edge.
  always_comb begin
    state_nxt = state;
    cap_nxt   = cap;
    stall_nxt = stall_cnt;
    armed_nxt = pass_armed;
    pass_nxt  = pass_cnt;
    err       = '0;
    hs        = valid && ready;

    case (state)
      ST_IDLE: begin
        if (valid && !ready) begin
          state_nxt = ST_WAIT;
          cap_nxt   = data;
          stall_nxt = STALL_ONE;
          if (STALL_ONE == STALL_LIM) err[ERR_BIT_STALL] = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!valid) begin
          err[ERR_BIT_DROP] = 1'b1;
          state_nxt         = ST_IDLE;
          stall_nxt         = '0;
        end else begin
          if (data != cap) begin
            err[ERR_BIT_DATA] = 1'b1;
            cap_nxt           = data;
          end
          if (ready) begin
            state_nxt = ST_IDLE;
            stall_nxt = '0;
          end else if (stall_cnt != STALL_LIM) begin
            // Counter saturates at the limit so the timeout fires once.
            stall_nxt = stall_cnt + STALL_ONE;
            if (stall_cnt + STALL_ONE == STALL_LIM) err[ERR_BIT_STALL] = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Only one outstanding transfer is tracked; dn_valid on the handshake
    // edge itself does not count because the timer is not yet armed.
    if (pass_armed) begin
      if (dn_valid) begin
        armed_nxt = 1'b0;
      end else if (pass_cnt == PASS_LIM) begin
        err[ERR_BIT_PASS] = 1'b1;
        armed_nxt         = 1'b0;
      end else begin
        pass_nxt = pass_cnt + PASS_ONE;
      end
    end else if (hs) begin
      armed_nxt = 1'b1;
      pass_nxt  = PASS_ONE;
    end
  end

endmodule

// File: rtl/axil_handshake_monitor.sv
// Multi-channel valid/ready protocol monitor. Each channel runs its own
// checker; this level picks one error per cycle to report (lowest channel,
// then lowest code), keeps per-channel sticky flags and a saturating count.
module axil_handshake_monitor
  import axil_mon_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int STALL_MAX = 16,
  parameter int PASS_MAX  = 5,
  parameter int CNT_W     = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        dn_valid,
  input  logic                     err_clear,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic [CH_W-1:0]          err_ch,
  output logic [NUM_CH-1:0]        err_sticky,
  output logic [CNT_W-1:0]         err_count,
  output logic [NUM_CH-1:0]        dbg_wait
);

  localparam int ERRS_W = cnt_width(NUM_CH * ERR_NUM);
  localparam int SUM_W  = CNT_W + ERRS_W;

  logic [NUM_CH-1:0][ERR_NUM-1:0] ch_err;
  ch_state_e                      ch_state [NUM_CH];

  logic              rep_valid;
  err_code_e         rep_code;
  err_code_e         err_code_r;
  logic [CH_W-1:0]   rep_ch;
  logic [NUM_CH-1:0] any_vec;
  logic [ERRS_W-1:0] n_err;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axil_mon_channel #(
      .DATA_W    (DATA_W),
      .STALL_MAX (STALL_MAX),
      .PASS_MAX  (PASS_MAX)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .valid    (ch_valid[g]),
      .ready    (ch_ready[g]),
      .data     (ch_data[g*DATA_W +: DATA_W]),
      .dn_valid (dn_valid[g]),
      .err      (ch_err[g]),
      .state    (ch_state[g])
    );
    assign dbg_wait[g] = (ch_state[g] == ST_WAIT);
  end

  // Priority selection and error population count for this cycle.
  always_comb begin
    rep_valid = 1'b0;
    rep_code  = ERR_NONE;
    rep_ch    = '0;
    any_vec   = '0;
    n_err     = '0;
    // Scan high to low so the lowest channel / lowest code wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      any_vec[i] = |ch_err[i];
      for (int k = ERR_NUM - 1; k >= 0; k--) begin
        n_err = n_err + ERRS_W'(ch_err[i][k]);
      end
      if (|ch_err[i]) begin
        rep_valid = 1'b1;
        rep_ch    = CH_W'(i);
        for (int k = ERR_NUM - 1; k >= 0; k--) begin
          if (ch_err[i][k]) rep_code = err_code_e'(3'(k + 1));
        end
      end
    end
    // Clear first, then add this cycle's errors, saturating at all-ones.
    sum = (err_clear ? SUM_W'(0) : SUM_W'(err_count)) + SUM_W'(n_err);
    if (sat_hit(64'(sum), CNT_W)) cnt_nxt = '1;
    else                           cnt_nxt = sum[CNT_W-1:0];
  end

  // Registered error report, sticky flags and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid  <= 1'b0;
      err_code_r <= ERR_NONE;
      err_ch     <= '0;
      err_sticky <= '0;
      err_count  <= '0;
    end else begin
      err_valid  <= rep_valid;
      err_code_r <= rep_code;
      err_ch     <= rep_ch;
      err_sticky <= (err_clear ? '0 : err_sticky) | any_vec;
      err_count  <= cnt_nxt;
    end
  end

  assign err_code = err_code_r;

endmodule

// File: tb/tb_axil_handshake_monitor.sv
// Directed bench for axil_handshake_monitor. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point, so each tick()
// shows the registered result of the inputs sampled at that edge.
module tb_axil_handshake_monitor;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_valid, ch_ready, dn_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     err_clear;

  logic              err_valid, err_valid2;
  logic [2:0]        err_code, err_code2;
  logic [1:0]        err_ch, err_ch2;
  logic [NUM_CH-1:0] err_sticky, err_sticky2;
  logic [15:0]       err_count;
  logic [1:0]        err_count2;
  logic [NUM_CH-1:0] dbg_wait, dbg_wait2;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock and DUTs: default build plus a 2-bit counter build on shared inputs.
  always #5 clk = ~clk;

  axil_handshake_monitor dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_data(ch_data), .dn_valid(dn_valid), .err_clear(err_clear),
    .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
    .err_sticky(err_sticky), .err_count(err_count), .dbg_wait(dbg_wait)
  );

  axil_handshake_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_data(ch_data), .dn_valid(dn_valid), .err_clear(err_clear),
    .err_valid(err_valid2), .err_code(err_code2), .err_ch(err_ch2),
    .err_sticky(err_sticky2), .err_count(err_count2), .dbg_wait(dbg_wait2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
    ch_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic idle_inputs();
    ch_valid = '0; ch_ready = '0; dn_valid = '0; err_clear = 1'b0;
  endtask

  task automatic check_report(input string tag, input logic v, input logic [2:0] code,
                              input logic [1:0] ch);
    check({tag, "_valid"}, 32'(err_valid), 32'(v));
    check({tag, "_code"},  32'(err_code),  32'(code));
    check({tag, "_ch"},    32'(err_ch),    32'(ch));
  endtask

  initial begin
    idle_inputs();
    ch_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_report("reset", 1'b0, 3'd0, 2'd0);
    check("reset_sticky", 32'(err_sticky), 32'h0);
    check("reset_count",  32'(err_count),  32'h0);
    check("reset_wait",   32'(dbg_wait),   32'h0);

    // Legal stall on ch0, then handshake and prompt downstream valid.
    ch_valid[0] = 1'b1; set_data(0, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ok_valid", 32'(err_valid), 32'h0);
    end
    check("stall_ok_wait", 32'(dbg_wait), 32'h1);
    ch_ready[0] = 1'b1;
    tick();
    check("hs_ok_valid", 32'(err_valid), 32'h0);
    idle_inputs(); dn_valid[0] = 1'b1;
    tick();
    dn_valid[0] = 1'b0;
    check("legal_count", 32'(err_count), 32'h0);
    check("legal_wait",  32'(dbg_wait),  32'h0);

    // Data change on ch1 while waiting.
    ch_valid[1] = 1'b1; set_data(1, 32'h10);
    tick();
    set_data(1, 32'h11);
    tick();
    check_report("dchg", 1'b1, 3'd2, 2'd1);
    check("dchg_sticky", 32'(err_sticky), 32'b0010);
    check("dchg_count",  32'(err_count),  32'h1);
    ch_ready[1] = 1'b1;
    tick();
    check("dchg_strobe_once", 32'(err_valid), 32'h0);
    idle_inputs(); dn_valid[1] = 1'b1;
    tick();
    dn_valid[1] = 1'b0;

    // Clear, then a 16-cycle stall on ch2 (single timeout).
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clear_count",  32'(err_count),  32'h0);
    check("clear_sticky", 32'(err_sticky), 32'h0);
    ch_valid[2] = 1'b1; set_data(2, 32'h77);
    for (int i = 1; i <= 15; i++) tick();
    check("stall15_valid", 32'(err_valid), 32'h0);
    tick();
    check_report("stall16", 1'b1, 3'd3, 2'd2);
    tick();
    check("stall17_no_repeat", 32'(err_valid), 32'h0);
    tick();
    check("stall18_no_repeat", 32'(err_valid), 32'h0);
    ch_ready[2] = 1'b1;
    tick();
    idle_inputs(); dn_valid[2] = 1'b1;
    tick();
    dn_valid[2] = 1'b0;
    check("stall_count", 32'(err_count), 32'h1);

    // ch3 pass timeout: handshake, no downstream valid.
    ch_valid[3] = 1'b1; ch_ready[3] = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) tick();
    check("pass4_valid", 32'(err_valid), 32'h0);
    tick();
    check_report("pass5", 1'b1, 3'd4, 2'd3);
    check("pass5_count", 32'(err_count), 32'h2);

    // ch3 downstream valid at cycle 3: satisfied.
    ch_valid[3] = 1'b1; ch_ready[3] = 1'b1;
    tick();
    idle_inputs();
    tick(); tick();
    dn_valid[3] = 1'b1;
    tick();
    dn_valid[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pass_ok_valid", 32'(err_valid), 32'h0);
    end
    check("pass_ok_count", 32'(err_count), 32'h2);

    // dn_valid on the handshake edge itself does not satisfy the timer.
    ch_valid[3] = 1'b1; ch_ready[3] = 1'b1; dn_valid[3] = 1'b1;
    tick();
    idle_inputs();
    for (int i = 1; i <= 5; i++) tick();
    check_report("pass_same", 1'b1, 3'd4, 2'd3);
    check("pass_same_count", 32'(err_count), 32'h3);

    // Simultaneous ch0 valid drop and ch2 data change, with clear that cycle.
    ch_valid[0] = 1'b1; set_data(0, 32'h1);
    ch_valid[2] = 1'b1; set_data(2, 32'h5);
    tick();
    ch_valid[0] = 1'b0; set_data(2, 32'h6); err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_report("multi", 1'b1, 3'd1, 2'd0);
    check("multi_count",  32'(err_count),  32'h2);
    check("multi_sticky", 32'(err_sticky), 32'b0101);
    ch_ready[2] = 1'b1;
    tick();
    idle_inputs(); dn_valid[2] = 1'b1;
    tick();
    dn_valid[2] = 1'b0;

    // Saturation on the 2-bit counter build.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_reset_count", 32'(err_count2), 32'h0);
    ch_valid = 4'hF;
    tick();
    ch_valid = 4'h0;
    tick();
    check("sat4_count2", 32'(err_count2), 32'h3);
    check("sat4_count",  32'(err_count),  32'h4);
    check("sat4_ch",     32'(err_ch2),    32'h0);
    ch_valid[1] = 1'b1;
    tick();
    ch_valid[1] = 1'b0;
    tick();
    check("sat5_count2", 32'(err_count2), 32'h3);
    check("sat5_count",  32'(err_count),  32'h5);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("sat_clear_count2",  32'(err_count2),  32'h0);
    check("sat_clear_sticky2", 32'(err_sticky2), 32'h0);

    // Reset mid-WAIT and mid-pass abandons tracking silently.
    ch_valid[1] = 1'b1;
    tick();
    ch_valid[1] = 1'b0; rst = 1'b1;
    tick();
    check("rst_wait_valid", 32'(err_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("rst_wait_after", 32'(err_valid), 32'h0);
    ch_valid[3] = 1'b1; ch_ready[3] = 1'b1;
    tick();
    idle_inputs(); rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_pass_valid", 32'(err_valid), 32'h0);
    end
    check("rst_final_count",  32'(err_count),  32'h0);
    check("rst_final_sticky", 32'(err_sticky), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
